// File: rtl/joybus_multi_bridge.sv
// rtl/joybus_multi_bridge.sv - multi-channel JOYBUS status word to UART frame bridge
// Round-robin serialises per-channel 32-bit words into {tag|ch, b31..b0} 5-byte frames.
module joybus_multi_bridge #(
  parameter int         NUM_CH       = 4,
  parameter int         STALE_CYCLES = 2_000_000,
  parameter logic [3:0] HDR_TAG      = 4'hA
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_CH*32-1:0] cntlr_data_i,
  input  logic [NUM_CH-1:0]    cntlr_data_rdy_i,
  input  logic                 mode_on_change_i,
  output logic [7:0]           tx_data_o,
  output logic                 tx_valid_o,
  input  logic                 tx_ready_i,
  output logic [NUM_CH-1:0]    ch_stale_o,
  output logic [7:0]           drop_cnt_o
);
  localparam int SW = $clog2(STALE_CYCLES + 1);
  localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_B3, S_B2, S_B1, S_B0} state_e;
  state_e state_q, state_d;

  logic [31:0]       latch_q [NUM_CH];
  logic [31:0]       last_q  [NUM_CH];
  logic [SW-1:0]     stale_q [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d, sent_q, rot;
  logic [31:0]       shadow_q, sel_word;
  logic [3:0]        gnt_q, gnt_d, rr_q, rr_d;
  logic [7:0]        drop_q, drop_d;
  logic [4:0]        ndrop;
  logic [8:0]        dsum;
  logic              grant, b0_fire;
  int                g, gn;

  // Rotate pending so bit 0 is the rr pointer; first set bit wins.
  always_comb begin
    grant    = 1'b0;
    gnt_d    = gnt_q;
    rr_d     = rr_q;
    g        = 0;
    gn       = 0;
    sel_word = '0;
    pend_d   = pend_q;
    ndrop    = '0;
    rot      = NUM_CH'({pend_q, pend_q} >> rr_q);
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant && rot[i] && state_q == S_IDLE) begin
        grant = 1'b1;
        g     = int'(rr_q) + i;
        if (g >= NUM_CH) g = g - NUM_CH;
        gn    = g + 1;
        if (gn >= NUM_CH) gn = 0;
        gnt_d = 4'(g);
        rr_d  = 4'(gn);
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant && gnt_d == 4'(k)) begin
        sel_word  = latch_q[k];
        pend_d[k] = 1'b0;
      end
      if (cntlr_data_rdy_i[k]) begin
        if (pend_q[k] && !(grant && gnt_d == 4'(k))) ndrop = ndrop + 5'd1;
        if (!(mode_on_change_i && sent_q[k] && cntlr_data_i[k*32 +: 32] == last_q[k]))
          pend_d[k] = 1'b1;
      end
    end
    dsum   = {1'b0, drop_q} + {4'd0, ndrop};
    drop_d = dsum[8] ? 8'hFF : dsum[7:0];
  end

  always_comb begin
    state_d    = state_q;
    tx_valid_o = 1'b0;
    tx_data_o  = 8'h00;
    b0_fire    = 1'b0;
    case (state_q)
      S_IDLE: if (grant) state_d = S_HDR;
      S_HDR: begin
        tx_valid_o = 1'b1;
        tx_data_o  = {HDR_TAG, gnt_q};
        if (tx_ready_i) state_d = S_B3;
      end
      S_B3: begin
        tx_valid_o = 1'b1;
        tx_data_o  = shadow_q[31:24];
        if (tx_ready_i) state_d = S_B2;
      end
      S_B2: begin
        tx_valid_o = 1'b1;
        tx_data_o  = shadow_q[23:16];
        if (tx_ready_i) state_d = S_B1;
      end
      S_B1: begin
        tx_valid_o = 1'b1;
        tx_data_o  = shadow_q[15:8];
        if (tx_ready_i) state_d = S_B0;
      end
      S_B0: begin
        tx_valid_o = 1'b1;
        tx_data_o  = shadow_q[7:0];
        b0_fire    = tx_ready_i;
        if (tx_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ch_stale_o = '0;
    for (int k = 0; k < NUM_CH; k++) ch_stale_o[k] = (stale_q[k] == STALE_MAX);
  end

  assign drop_cnt_o = drop_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      pend_q   <= '0;
      sent_q   <= '0;
      shadow_q <= '0;
      gnt_q    <= '0;
      rr_q     <= '0;
      drop_q   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        latch_q[k] <= '0;
        last_q[k]  <= '0;
        stale_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
      if (grant) begin
        shadow_q <= sel_word;
        gnt_q    <= gnt_d;
        rr_q     <= rr_d;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (cntlr_data_rdy_i[k]) latch_q[k] <= cntlr_data_i[k*32 +: 32];
        if (b0_fire && gnt_q == 4'(k)) begin
          last_q[k] <= shadow_q;
          sent_q[k] <= 1'b1;
        end
        if (cntlr_data_rdy_i[k])          stale_q[k] <= '0;
        else if (stale_q[k] != STALE_MAX) stale_q[k] <= stale_q[k] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_joybus_multi_bridge.sv
// tb/tb_joybus_multi_bridge.sv - directed self-checking bench for joybus_multi_bridge
// Linear directed steps; expected bytes and counts are hand-derived constants.
module tb_joybus_multi_bridge;
  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] cntlr_data;
  logic [3:0]   cntlr_data_rdy;
  logic         mode_on_change;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic [3:0]   ch_stale;
  logic [7:0]   drop_cnt;
  int           checks = 0;
  int           errors = 0;
  int           seen;

  joybus_multi_bridge #(.NUM_CH(4), .STALE_CYCLES(100), .HDR_TAG(4'hA)) dut (
    .clk_i(clk), .rst_i(rst), .cntlr_data_i(cntlr_data), .cntlr_data_rdy_i(cntlr_data_rdy),
    .mode_on_change_i(mode_on_change), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready), .ch_stale_o(ch_stale), .drop_cnt_o(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input int ch, input logic [31:0] w);
    cntlr_data[ch*32 +: 32] = w;
    cntlr_data_rdy[ch]      = 1'b1;
  endtask

  task automatic expect_frame(input logic [7:0] hdr, input logic [31:0] w, input string tag);
    logic [7:0] e [5];
    int n;
    e[0] = hdr; e[1] = w[31:24]; e[2] = w[23:16]; e[3] = w[15:8]; e[4] = w[7:0];
    for (int b = 0; b < 5; b++) begin
      n = 0;
      while (!tx_valid && n < 50) begin
        tick();
        n++;
      end
      chk($sformatf("%s b%0d", tag, b), {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, e[b]});
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; cntlr_data = '0; cntlr_data_rdy = '0; mode_on_change = 1'b0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {tx_valid, tx_data, ch_stale, drop_cnt}, 21'd0);
    rst = 1'b0;

    // stale: counter reaches 100 on the 100th edge after release
    repeat (99) tick();
    chk("stale at 99", ch_stale, 4'h0);
    tick();
    chk("stale at 100", ch_stale, 4'hF);
    repeat (5) tick();
    chk("stale holds", ch_stale, 4'hF);
    strobe(3, 32'hCAFE_0003);
    tick();
    cntlr_data_rdy = '0;
    chk("stale ch3 cleared", ch_stale, 4'b0111);
    expect_frame(8'hA3, 32'hCAFE_0003, "ch3 frame");

    // round-robin: simultaneous burst from rr=0
    strobe(0, 32'h0000_0010); strobe(1, 32'h1111_0011); strobe(2, 32'h2222_0012); strobe(3, 32'h3333_0013);
    tick();
    cntlr_data_rdy = '0;
    expect_frame(8'hA0, 32'h0000_0010, "rr1 ch0");
    chk("idle gap", tx_valid, 1'b0);
    expect_frame(8'hA1, 32'h1111_0011, "rr1 ch1");
    expect_frame(8'hA2, 32'h2222_0012, "rr1 ch2");
    expect_frame(8'hA3, 32'h3333_0013, "rr1 ch3");
    strobe(0, 32'h0A0A_0A0A); strobe(1, 32'h1B1B_1B1B);
    tick();
    cntlr_data_rdy = '0;
    expect_frame(8'hA0, 32'h0A0A_0A0A, "rr2 ch0");
    expect_frame(8'hA1, 32'h1B1B_1B1B, "rr2 ch1");
    strobe(0, 32'h4000_0000); strobe(1, 32'h4100_0001); strobe(2, 32'h4200_0002); strobe(3, 32'h4300_0003);
    tick();
    cntlr_data_rdy = '0;
    expect_frame(8'hA2, 32'h4200_0002, "rr3 ch2");
    expect_frame(8'hA3, 32'h4300_0003, "rr3 ch3");
    expect_frame(8'hA0, 32'h4000_0000, "rr3 ch0");
    expect_frame(8'hA1, 32'h4100_0001, "rr3 ch1");

    // single frame with latency
    strobe(2, 32'h1234_5678);
    tick();
    cntlr_data_rdy = '0;
    chk("lat t+1 idle", tx_valid, 1'b0);
    tick();
    chk("lat t+2 hdr", {tx_valid, tx_data}, {1'b1, 8'hA2});
    tick(); chk("single b3", {tx_valid, tx_data}, {1'b1, 8'h12});
    tick(); chk("single b2", {tx_valid, tx_data}, {1'b1, 8'h34});
    tick(); chk("single b1", {tx_valid, tx_data}, {1'b1, 8'h56});
    tick(); chk("single b0", {tx_valid, tx_data}, {1'b1, 8'h78});
    tick(); chk("single end", tx_valid, 1'b0);

    // backpressure in the [23:16] and [15:8] byte states
    strobe(1, 32'hA1B2_C3D4);
    tick();
    cntlr_data_rdy = '0;
    tick(); chk("bp hdr", {tx_valid, tx_data}, {1'b1, 8'hA1});
    tick(); chk("bp b3", {tx_valid, tx_data}, {1'b1, 8'hA1});
    tick(); chk("bp b2", {tx_valid, tx_data}, {1'b1, 8'hB2});
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); chk($sformatf("bp hold b2 %0d", i), {tx_valid, tx_data}, {1'b1, 8'hB2});
    end
    tx_ready = 1'b1;
    tick(); chk("bp b1", {tx_valid, tx_data}, {1'b1, 8'hC3});
    tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(); chk($sformatf("bp hold b1 %0d", i), {tx_valid, tx_data}, {1'b1, 8'hC3});
    end
    tx_ready = 1'b1;
    tick(); chk("bp b0", {tx_valid, tx_data}, {1'b1, 8'hD4});
    tick(); chk("bp end", tx_valid, 1'b0);

    // send-on-change on ch1
    mode_on_change = 1'b1;
    strobe(1, 32'hDEAD_BEEF);
    tick();
    cntlr_data_rdy = '0;
    expect_frame(8'hA1, 32'hDEAD_BEEF, "chg first");
    strobe(1, 32'hDEAD_BEEF);
    tick();
    cntlr_data_rdy = '0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (tx_valid) seen++;
      tick();
    end
    chk("chg repeat suppressed", seen, 0);
    strobe(1, 32'hDEAD_BEE0);
    tick();
    cntlr_data_rdy = '0;
    expect_frame(8'hA1, 32'hDEAD_BEE0, "chg third");
    mode_on_change = 1'b0;
    chk("drop before flood", drop_cnt, 8'd0);

    // drop counter saturation: 300 back-to-back ch0 strobes, UART stalled
    tx_ready = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      strobe(0, 32'h5000_0000 + i);
      tick();
      if (i == 100) chk("drop after 100", drop_cnt, 8'd98);
    end
    cntlr_data_rdy = '0;
    chk("drop saturated", drop_cnt, 8'd255);
    repeat (3) tick();
    chk("drop holds", drop_cnt, 8'd255);
    tx_ready = 1'b1;
    expect_frame(8'hA0, 32'h5000_0001, "flood first");
    expect_frame(8'hA0, 32'h5000_012C, "flood newest");

    // asynchronous reset mid-frame
    strobe(2, 32'h0BAD_F00D);
    tick();
    cntlr_data_rdy = '0;
    tick(); tick(); tick(); tick();
    chk("pre-reset b1", {tx_valid, tx_data}, {1'b1, 8'hF0});
    #2 rst = 1'b1;
    #1;
    chk("async reset valid", tx_valid, 1'b0);
    chk("async reset drop", drop_cnt, 8'd0);
    chk("async reset data", tx_data, 8'h00);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tx_valid) seen++;
    end
    chk("no resume after reset", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
